// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: load/store handshake with wait states,
// timeout abort, and load extension. The optional alignment check is enabled by MEM_ALIGN_CHECK_EN.
module mem_access_unit #(
   parameter int MAX_WAIT = 255,
   parameter int CNT_W    = 16
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        I_MEM_Valid,
   input  logic        I_MEM_Read,
   input  logic        I_MEM_Write,
   input  logic [1:0]  I_MEM_Size,
   input  logic        I_MEM_Unsigned,
   input  logic [31:0] I_MEM_ADDR,
   input  logic [31:0] I_MEM_WriteData,
   output logic        O_DM_Req,
   output logic        O_DM_We,
   output logic [31:0] O_DM_ADDR,
   output logic [31:0] O_DM_WData,
   output logic [3:0]  O_DM_ByteEn,
   input  logic        I_DM_Ready,
   input  logic [31:0] I_DM_RData,
   output logic        O_MEM_Stall,
   output logic [31:0] O_MEM_ReadData,
   output logic        O_MEM_Done,
   output logic        O_MEM_Timeout,
   output logic        O_MEM_Misaligned,
   output logic [1:0]  O_DBG_State
);

   // Handshake: O_DM_Req stays high for the whole ACCESS state with stable
   // address/data/enables; the transfer completes on the first cycle I_DM_Ready is high.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       be_q, be_d;
   logic [1:0]       size_q, size_d;
   logic             uns_q, uns_d;
   logic             we_q, we_d;
   logic             tout_q, tout_d;
   logic [31:0]      rdata_q, rdata_d;

   logic             req_valid;
   logic             accept;
   logic [3:0]       fmt_be;
   logic [31:0]      fmt_wdata;
   logic [31:0]      ext_rdata;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;

   assign req_valid = I_MEM_Valid & (I_MEM_Read | I_MEM_Write);

`ifdef MEM_ALIGN_CHECK_EN
   logic mis_req;
   logic mis_q, mis_d;

   always_comb begin
      mis_req = 1'b0;
      case (I_MEM_Size)
         2'b00:   mis_req = 1'b0;
         2'b01:   mis_req = I_MEM_ADDR[0];
         default: mis_req = |I_MEM_ADDR[1:0];
      endcase
   end

   assign accept           = req_valid & ~mis_req;
   assign O_MEM_Misaligned = mis_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) mis_q <= 1'b0;
      else       mis_q <= mis_d;
   end

   assign mis_d = (state_q == S_IDLE) & req_valid & mis_req;
`else
   assign accept           = req_valid;
   assign O_MEM_Misaligned = 1'b0;
`endif

   // Store formatting: replicate the datum across lanes, enable only the addressed lanes.
   always_comb begin
      fmt_be    = 4'b1111;
      fmt_wdata = I_MEM_WriteData;
      case (I_MEM_Size)
         2'b00: begin
            fmt_be    = 4'b0001 << I_MEM_ADDR[1:0];
            fmt_wdata = {4{I_MEM_WriteData[7:0]}};
         end
         2'b01: begin
            fmt_be    = I_MEM_ADDR[1] ? 4'b1100 : 4'b0011;
            fmt_wdata = {2{I_MEM_WriteData[15:0]}};
         end
         default: begin
            fmt_be    = 4'b1111;
            fmt_wdata = I_MEM_WriteData;
         end
      endcase
   end

   // Load extraction uses the latched lane/size so input changes during ACCESS are ignored.
   always_comb begin
      ld_byte = I_DM_RData[7:0];
      case (addr_q[1:0])
         2'd0: ld_byte = I_DM_RData[7:0];
         2'd1: ld_byte = I_DM_RData[15:8];
         2'd2: ld_byte = I_DM_RData[23:16];
         2'd3: ld_byte = I_DM_RData[31:24];
         default: ld_byte = I_DM_RData[7:0];
      endcase
      ld_half = addr_q[1] ? I_DM_RData[31:16] : I_DM_RData[15:0];

      ext_rdata = I_DM_RData;
      case (size_q)
         2'b00:   ext_rdata = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
         2'b01:   ext_rdata = {{16{ld_half[15] & ~uns_q}}, ld_half};
         default: ext_rdata = I_DM_RData;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         we_q    <= 1'b0;
         tout_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         we_q    <= we_d;
         tout_q  <= tout_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      size_d  = size_q;
      uns_d   = uns_q;
      we_d    = we_q;
      tout_d  = tout_q;
      rdata_d = rdata_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               addr_d  = I_MEM_ADDR;
               wdata_d = fmt_wdata;
               be_d    = fmt_be;
               size_d  = I_MEM_Size;
               uns_d   = I_MEM_Unsigned;
               we_d    = I_MEM_Write;
               tout_d  = 1'b0;
               cnt_d   = '0;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (I_DM_Ready) begin
               if (!we_q) rdata_d = ext_rdata;
               state_d = S_DONE;
            end else if (cnt_q == LAST_WAIT) begin
               tout_d  = 1'b1;
               if (!we_q) rdata_d = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign O_DM_Req       = (state_q == S_ACCESS);
   assign O_DM_We        = (state_q == S_ACCESS) & we_q;
   assign O_DM_ADDR      = {addr_q[31:2], 2'b00};
   assign O_DM_WData     = wdata_q;
   assign O_DM_ByteEn    = be_q;
   assign O_MEM_Stall    = ((state_q == S_IDLE) & accept) | (state_q == S_ACCESS);
   assign O_MEM_ReadData = rdata_q;
   assign O_MEM_Done     = (state_q == S_DONE);
   assign O_MEM_Timeout  = (state_q == S_DONE) & tout_q;
   assign O_DBG_State    = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of loads/stores plus wait-state,
// timeout, mid-access reset and alignment sequences.
module tb_mem_access_unit;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        I_MEM_Valid, I_MEM_Read, I_MEM_Write, I_MEM_Unsigned;
   logic [1:0]  I_MEM_Size;
   logic [31:0] I_MEM_ADDR, I_MEM_WriteData;
   logic        I_DM_Ready;
   logic [31:0] I_DM_RData;

   logic        O_DM_Req, O_DM_We, O_MEM_Stall, O_MEM_Done, O_MEM_Timeout, O_MEM_Misaligned;
   logic [31:0] O_DM_ADDR, O_DM_WData, O_MEM_ReadData;
   logic [3:0]  O_DM_ByteEn;
   logic [1:0]  O_DBG_State;

   logic        t_Req, t_We, t_Stall, t_Done, t_Timeout, t_Misaligned;
   logic [31:0] t_ADDR, t_WData, t_ReadData;
   logic [3:0]  t_ByteEn;
   logic [1:0]  t_State;

   int n_chk  = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];

   always #5 CLK = ~CLK;

   mem_access_unit dut (
      .CLK(CLK), .RESET(RESET),
      .I_MEM_Valid(I_MEM_Valid), .I_MEM_Read(I_MEM_Read), .I_MEM_Write(I_MEM_Write),
      .I_MEM_Size(I_MEM_Size), .I_MEM_Unsigned(I_MEM_Unsigned), .I_MEM_ADDR(I_MEM_ADDR),
      .I_MEM_WriteData(I_MEM_WriteData),
      .O_DM_Req(O_DM_Req), .O_DM_We(O_DM_We), .O_DM_ADDR(O_DM_ADDR), .O_DM_WData(O_DM_WData),
      .O_DM_ByteEn(O_DM_ByteEn), .I_DM_Ready(I_DM_Ready), .I_DM_RData(I_DM_RData),
      .O_MEM_Stall(O_MEM_Stall), .O_MEM_ReadData(O_MEM_ReadData), .O_MEM_Done(O_MEM_Done),
      .O_MEM_Timeout(O_MEM_Timeout), .O_MEM_Misaligned(O_MEM_Misaligned),
      .O_DBG_State(O_DBG_State)
   );

   mem_access_unit #(.MAX_WAIT(4)) dut_to (
      .CLK(CLK), .RESET(RESET),
      .I_MEM_Valid(I_MEM_Valid), .I_MEM_Read(I_MEM_Read), .I_MEM_Write(I_MEM_Write),
      .I_MEM_Size(I_MEM_Size), .I_MEM_Unsigned(I_MEM_Unsigned), .I_MEM_ADDR(I_MEM_ADDR),
      .I_MEM_WriteData(I_MEM_WriteData),
      .O_DM_Req(t_Req), .O_DM_We(t_We), .O_DM_ADDR(t_ADDR), .O_DM_WData(t_WData),
      .O_DM_ByteEn(t_ByteEn), .I_DM_Ready(I_DM_Ready), .I_DM_RData(I_DM_RData),
      .O_MEM_Stall(t_Stall), .O_MEM_ReadData(t_ReadData), .O_MEM_Done(t_Done),
      .O_MEM_Timeout(t_Timeout), .O_MEM_Misaligned(t_Misaligned),
      .O_DBG_State(t_State)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rdata;
      logic [3:0]  exp_be;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic        exp_we;
      logic [31:0] exp_read;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_req(input vec_t v);
      I_MEM_Valid     = 1'b1;
      I_MEM_Read      = v.rd;
      I_MEM_Write     = v.wr;
      I_MEM_Size      = v.size;
      I_MEM_Unsigned  = v.uns;
      I_MEM_ADDR      = v.addr;
      I_MEM_WriteData = v.wd;
   endtask

   task automatic scramble_inputs();
      I_MEM_Valid     = 1'b0;
      I_MEM_Read      = 1'($urandom_range(0, 1));
      I_MEM_Write     = 1'($urandom_range(0, 1));
      I_MEM_Size      = 2'($urandom_range(0, 3));
      I_MEM_ADDR      = $urandom;
      I_MEM_WriteData = $urandom;
   endtask

   // Request cycle, ACCESS cycles (Ready after 'delay' wait cycles), DONE cycle, idle cycle.
   task automatic run_txn(input vec_t v, input int delay);
      int   k;
      logic got;
      exp_q.push_back(v.exp_read);
      @(negedge CLK);
      drive_req(v);
      #1;
      check("stall_req_cycle", O_MEM_Stall, 1);
      check("req_low_idle", O_DM_Req, 0);
      @(negedge CLK);
      scramble_inputs();
      k   = 0;
      got = 1'b0;
      while (!got && k < 300) begin
         check("dm_req", O_DM_Req, 1);
         check("dm_addr", O_DM_ADDR, v.exp_addr);
         check("dm_byteen", O_DM_ByteEn, v.exp_be);
         check("dm_wdata", O_DM_WData, v.exp_wdata);
         check("dm_we", O_DM_We, v.exp_we);
         check("stall_access", O_MEM_Stall, 1);
         check("done_early", O_MEM_Done, 0);
         if (k == delay) begin
            I_DM_Ready = 1'b1;
            I_DM_RData = v.rdata;
            got        = 1'b1;
         end else begin
            I_DM_Ready = 1'b0;
            I_DM_RData = $urandom;
         end
         @(negedge CLK);
         k++;
      end
      I_DM_Ready = 1'b0;
      I_DM_RData = $urandom;
      check("access_cycles", k, delay + 1);
      check("done_pulse", O_MEM_Done, 1);
      check("timeout_low", O_MEM_Timeout, 0);
      check("stall_done", O_MEM_Stall, 0);
      check("req_done", O_DM_Req, 0);
      check("read_data", O_MEM_ReadData, exp_q.pop_front());
      @(negedge CLK);
      check("done_single", O_MEM_Done, 0);
      check("stall_idle", O_MEM_Stall, 0);
   endtask

   initial begin
      vec_t v;
      int   k;

      //          rd    wr    sz     u     addr          wd            rdata         be       eaddr         ewdata        we    read
      vecs[0] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 4'b1111, 32'h0000_0100, 32'h0,        1'b0, 32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0,        32'h8011_2233, 4'b1000, 32'h0000_0100, 32'h0,        1'b0, 32'hFFFF_FF80};
      vecs[2] = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0,        32'h8011_2233, 4'b1000, 32'h0000_0100, 32'h0,        1'b0, 32'h0000_0080};
      vecs[3] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0,        32'h8011_2233, 4'b1100, 32'h0000_0100, 32'h0,        1'b0, 32'hFFFF_8011};
      vecs[4] = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0100, 32'h0,        32'h8011_2233, 4'b0011, 32'h0000_0100, 32'h0,        1'b0, 32'h0000_2233};
      vecs[5] = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0201, 32'hFFFF_FFA5, 32'h5555_5555, 4'b0010, 32'h0000_0200, 32'hA5A5_A5A5, 1'b1, 32'h0000_2233};
      vecs[6] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_1234, 32'h5555_5555, 4'b1100, 32'h0000_0200, 32'h1234_1234, 1'b1, 32'h0000_2233};
      vecs[7] = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 32'h5555_5555, 4'b1111, 32'h0000_0300, 32'hCAFE_F00D, 1'b1, 32'h0000_2233};
      vecs[8] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0,        32'h0000_7F00, 4'b0010, 32'h0000_0100, 32'h0,        1'b0, 32'h0000_007F};
      vecs[9] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_0104, 32'h0,        32'h1234_5678, 4'b1111, 32'h0000_0104, 32'h0,        1'b0, 32'h1234_5678};

      // Clock/reset block
      RESET = 1'b1;
      I_MEM_Valid = 0; I_MEM_Read = 0; I_MEM_Write = 0; I_MEM_Size = 0; I_MEM_Unsigned = 0;
      I_MEM_ADDR = 0; I_MEM_WriteData = 0; I_DM_Ready = 0; I_DM_RData = 0;
      repeat (2) @(negedge CLK);
      check("rst_req", O_DM_Req, 0);
      check("rst_state", O_DBG_State, 0);
      check("rst_rdata", O_MEM_ReadData, 0);
      check("rst_byteen", O_DM_ByteEn, 0);
      check("rst_done", O_MEM_Done, 0);
      RESET = 1'b0;

      // Vector table, Ready on first ACCESS cycle
      for (int i = 0; i < 10; i++) run_txn(vecs[i], 0);

      // Timeout on the MAX_WAIT=4 instance; main instance keeps waiting
      @(negedge CLK);
      v = vecs[0];
      v.addr = 32'h0000_0400;
      drive_req(v);
      @(negedge CLK);
      scramble_inputs();
      k = 0;
      while (!t_Done && k < 20) begin
         check("to_req", t_Req, 1);
         @(negedge CLK);
         k++;
      end
      check("to_access_cycles", k, 4);
      check("to_done", t_Done, 1);
      check("to_timeout", t_Timeout, 1);
      check("to_rdata_zero", t_ReadData, 0);
      check("main_still_waiting", O_DM_Req, 1);

      // Reset in the middle of the main instance's ACCESS
      #1 RESET = 1'b1;
      #1;
      check("midrst_req", O_DM_Req, 0);
      check("midrst_stall", O_MEM_Stall, 0);
      check("midrst_addr", O_DM_ADDR, 0);
      check("midrst_wdata", O_DM_WData, 0);
      check("midrst_byteen", O_DM_ByteEn, 0);
      check("midrst_we", O_DM_We, 0);
      check("midrst_rdata", O_MEM_ReadData, 0);
      check("midrst_done", O_MEM_Done, 0);
      check("midrst_timeout", O_MEM_Timeout, 0);
      @(negedge CLK);
      RESET = 1'b0;
      run_txn(vecs[0], 0);

      // Five wait cycles before Ready
      v = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_010E, 32'h0, 32'h7FFF_0000, 4'b1100,
            32'h0000_010C, 32'h0, 1'b0, 32'h0000_7FFF};
      run_txn(v, 5);

      // Word load at a misaligned address
`ifdef MEM_ALIGN_CHECK_EN
      @(negedge CLK);
      v = vecs[0];
      v.addr = 32'h0000_0102;
      drive_req(v);
      #1;
      check("mis_no_stall", O_MEM_Stall, 0);
      @(negedge CLK);
      scramble_inputs();
      check("mis_pulse", O_MEM_Misaligned, 1);
      check("mis_no_req", O_DM_Req, 0);
      check("mis_rdata_kept", O_MEM_ReadData, 32'h0000_7FFF);
      @(negedge CLK);
      check("mis_pulse_end", O_MEM_Misaligned, 0);
      check("mis_no_req2", O_DM_Req, 0);
`else
      v = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0, 32'hA5A5_0F0F, 4'b1111,
            32'h0000_0100, 32'h0, 1'b0, 32'hA5A5_0F0F};
      run_txn(v, 0);
      check("mis_tied_low", O_MEM_Misaligned, 0);
`endif

      // Valid without Read/Write, and Read without Valid: no request
      @(negedge CLK);
      I_MEM_Valid = 1'b1; I_MEM_Read = 1'b0; I_MEM_Write = 1'b0;
      #1;
      check("noreq_stall", O_MEM_Stall, 0);
      @(negedge CLK);
      check("noreq_req", O_DM_Req, 0);
      check("noreq_state", O_DBG_State, 0);
      I_MEM_Valid = 1'b0; I_MEM_Read = 1'b1;
      #1;
      check("novalid_stall", O_MEM_Stall, 0);
      @(negedge CLK);
      check("novalid_req", O_DM_Req, 0);
      I_MEM_Read = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access controller. It sits between the EX/MEM pipeline register and the MEM/WB register.
- Turns a load/store request into a handshaked transaction on the data-memory port. Memory may insert wait states.
- Stalls the pipeline until the transaction completes.
- Delivers sign/zero-extended load data (O_MEM_ReadData) to the MEM/WB register's read-data input.

Parameters:
- MAX_WAIT, 255: max cycles in ACCESS without I_DM_Ready before the transaction is aborted (1..65535).
- CNT_W, 16: width of the wait-state counter; must hold MAX_WAIT.

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  reset, asynchronous, active-high
- I_MEM_Valid  in  1  request valid from EX/MEM
- I_MEM_Read  in  1  load
- I_MEM_Write  in  1  store (wins if both Read and Write set)
- I_MEM_Size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- I_MEM_Unsigned  in  1  zero-extend loads (LBU/LHU) when 1
- I_MEM_ADDR  in  32  byte address
- I_MEM_WriteData  in  32  store data, right-justified
- O_DM_Req  out  1  memory request
- O_DM_We  out  1  1 = write
- O_DM_ADDR  out  32  word address, bits [1:0] = 00
- O_DM_WData  out  32  lane-replicated store data
- O_DM_ByteEn  out  4  byte lane enables
- I_DM_Ready  in  1  memory completes the transaction this cycle
- I_DM_RData  in  32  read word, valid when I_DM_Ready
- O_MEM_Stall  out  1  freeze upstream pipeline
- O_MEM_ReadData  out  32  extended load result to MEM/WB
- O_MEM_Done  out  1  one-cycle completion pulse
- O_MEM_Timeout  out  1  one-cycle pulse, transaction aborted
- O_MEM_Misaligned  out  1  one-cycle pulse, misaligned request rejected

Behaviour:
- Reset: RESET, asynchronous, active-high; clock CLK. Reset forces:
  - state IDLE, wait counter 0;
  - all request holding registers 0;
  - O_DM_Req, O_DM_We, O_DM_ADDR, O_DM_WData, O_DM_ByteEn, O_MEM_ReadData all 0;
  - O_MEM_Done, O_MEM_Timeout, O_MEM_Misaligned all 0.
  RESET mid-transaction drops O_DM_Req immediately and discards the transaction.
- Little-endian; byte lane = ADDR[1:0].
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: request = I_MEM_Valid & (Read|Write).
    - Valid request: latch ADDR, size, unsigned, write flag and formatted data; go to ACCESS.
    - No request (Valid=0, or Read=Write=0): stay in IDLE, no stall.
  - ACCESS:
    - O_DM_Req=1; O_DM_We, ADDR, WData and ByteEn come from the latched values, stable for the whole state.
    - Counter increments each cycle.
    - I_DM_Ready=1 (including the first ACCESS cycle): for a load, register the extended I_DM_RData into O_MEM_ReadData; go to DONE.
    - Counter reaches MAX_WAIT with no Ready: go to DONE with the timeout flag set; a load sets O_MEM_ReadData=0.
  - DONE: O_DM_Req=0; O_MEM_Done=1 (O_MEM_Timeout=1 if aborted); counter cleared; go to IDLE.
- O_MEM_Stall is combinational: (IDLE & valid request) | ACCESS. It is low in DONE so the pipeline advances and MEM/WB captures O_MEM_ReadData.
- Minimum latency: request cycle, 1 ACCESS cycle, DONE cycle, i.e. 3 cycles.
- O_MEM_ReadData is held until the next load completes; stores do not change it.
- Inputs changing during ACCESS/DONE are ignored. I_DM_Ready outside ACCESS is ignored.
- Store formatting:
  - byte: ByteEn = 0001<<ADDR[1:0], WData = 4 copies of the data byte;
  - half: ByteEn = 0011<<(2*ADDR[1]), WData = 2 copies of the data half;
  - word: ByteEn = 1111, WData = I_MEM_WriteData.
- Load extraction: select the byte/half by ADDR lanes; sign-extend unless Unsigned; word loads pass through.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: a misaligned request (half with ADDR[0]=1; word with ADDR[1:0]≠00) is rejected in IDLE:
  - O_MEM_Misaligned pulses for 1 cycle (registered, the cycle after the request);
  - no stall, no memory transaction, O_MEM_ReadData unchanged.
- Not defined: O_MEM_Misaligned is tied 0. Low address bits are ignored for alignment (half uses ADDR[1], word uses lane 0) and the access proceeds normally.

Test Plan:
- LW at 0x100, Ready on first ACCESS cycle, RData=0xDEADBEEF -> O_DM_ADDR=0x100, ByteEn=1111, Done pulse at cycle 3, ReadData=0xDEADBEEF, Stall high for exactly 2 cycles.
- LB at 0x103 with RData=0x80112233 -> ReadData=0xFFFFFF80; same with LBU -> 0x00000080; LH at 0x102 -> 0xFFFF8011.
- SB 0x000000A5 at 0x201 -> ByteEn=0010, WData=0xA5A5A5A5, We=1; SH 0x1234 at 0x202 -> ByteEn=1100, WData=0x12341234.
- Ready delayed 5 cycles -> Req and all DM outputs stable for 5 cycles, Stall high throughout, single Done pulse; with MAX_WAIT=4 and Ready never high -> Timeout+Done pulse after 4 ACCESS cycles, ReadData=0.
- RESET asserted mid-ACCESS -> Req=0 and Stall=0 immediately, all outputs 0, next request after reset completes normally.
- MEM_ALIGN_CHECK_EN defined, LW at 0x102 -> Misaligned pulse, Req never asserted, Stall=0; macro undefined -> access issued to 0x100.
